// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
// Runs one update pass per frame, starting when vertical blank begins. Each client
// is given its own request in turn, from client 0 upward, and is waited on until it
// acknowledges or times out. A one-cycle gap separates consecutive requests.
// The block also keeps sticky flags for client timeouts and for a pass that is still
// running when vblank ends or when the next vblank begins.
module frame_update_scheduler #(
   parameter  int N_CLIENTS   = 4,
   parameter  int TIMEOUT     = 4096,
   parameter  int FRAME_CNT_W = 16,
   localparam int IDX_W       = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
   input  logic                   pclk,
   input  logic                   rst,
   input  logic                   vblnk,
   input  logic                   enable,
   input  logic [N_CLIENTS-1:0]   upd_ack,
   input  logic                   err_clr,
   output logic [N_CLIENTS-1:0]   upd_req,
   output logic                   frame_tick,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy,
   output logic                   overrun,
   output logic                   timeout_err,
   output logic [IDX_W-1:0]       timeout_idx
);

   // The timer only has to reach TIMEOUT-1.
   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t           state, state_nxt;
   logic             vblnk_q;
   logic             primed;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] timer;

   logic rise, fall, start, cur_ack, tmo, done, last, set_to;

   // The first edge after reset only records vblnk. If vblank was already in progress
   // at that point, its level is not treated as a new vblank start.
   assign rise    = primed & vblnk & ~vblnk_q;
   assign fall    = primed & ~vblnk & vblnk_q;
   assign start   = (state == IDLE) & rise & enable;
   assign cur_ack = upd_ack[idx];
   assign tmo     = (timer == TMR_W'(TIMEOUT - 1));
   assign done    = cur_ack | tmo;
   assign last    = (idx == IDX_W'(N_CLIENTS - 1));
   assign set_to  = (state == REQ) & tmo & ~cur_ack;

   // State register
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state <= IDLE;
      // NOTE: registers are written with <= so that every flop samples its inputs as
      // they were before the clock edge, regardless of the order of the statements.
      else     state <= state_nxt;
   end

   // Next-state logic: move through the clients, with one gap cycle between them
   always_comb begin
      // NOTE: a default is assigned first so that every path drives the signal.
      // This prevents a latch from being inferred for any path that is not covered.
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = REQ;
         REQ:     if (done)  state_nxt = last ? IDLE : GAP;
         GAP:                state_nxt = REQ;
         default:            state_nxt = IDLE;
      endcase
   end

   // Outputs: a one-hot request while waiting on a client; busy for the whole pass
   always_comb begin
      upd_req = '0;
      if (state == REQ) upd_req = N_CLIENTS'(1) << idx;
      busy = (state != IDLE);
   end

   // Client index and per-request wait timer
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         timer <= '0;
      end else if (start) begin
         idx   <= '0;
         timer <= '0;
      end else if (state == REQ) begin
         if (done) begin
            timer <= '0;
            if (!last) idx <= idx + IDX_W'(1);
         end else begin
            timer <= timer + TMR_W'(1);
         end
      end else begin
         timer <= '0;
      end
   end

   // vblank edge history, plus a flag that arms edge detection after reset
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vblnk_q <= 1'b0;
         primed  <= 1'b0;
      end else begin
         vblnk_q <= vblnk;
         primed  <= 1'b1;
      end
   end

   // Frame tick and count of passes started
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_tick <= start;
         frame_cnt  <= frame_cnt + FRAME_CNT_W'(start);
      end
   end

   // Sticky error flags; a new error on the same edge as err_clr wins
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
         timeout_idx <= '0;
      end else begin
         if (busy && (rise || fall)) overrun <= 1'b1;
         else if (err_clr)           overrun <= 1'b0;

         if (set_to) begin
            timeout_err <= 1'b1;
            timeout_idx <= idx;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Testbench for frame_update_scheduler.
// vblank timing is compressed and randomized. Client acknowledge delays are planned
// once per pass. The expected request timeline is then derived from those plans:
// each client's slot is min(delay, TIMEOUT-1)+1 cycles long, and consecutive slots
// are separated by a single gap cycle.
module tb_frame_update_scheduler;

   localparam int N    = 4;
   localparam int TMO  = 16;
   localparam int CW   = 4;
   localparam int NCYC = 8000;

   logic          pclk, rst, vblnk, enable, err_clr;
   logic [N-1:0]  upd_ack, upd_req;
   logic          frame_tick, busy, overrun, timeout_err;
   logic [CW-1:0] frame_cnt;
   logic [1:0]    timeout_idx;

   frame_update_scheduler #(.N_CLIENTS(N), .TIMEOUT(TMO), .FRAME_CNT_W(CW)) dut (
      .pclk(pclk), .rst(rst), .vblnk(vblnk), .enable(enable), .upd_ack(upd_ack),
      .err_clr(err_clr), .upd_req(upd_req), .frame_tick(frame_tick),
      .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun),
      .timeout_err(timeout_err), .timeout_idx(timeout_idx)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model: one planned pass at a time ----------------
   bit seq_on;
   int s_start, s_end;
   int b[N], len[N], dly[N];
   bit m_ov, m_to;
   int m_tidx, m_cnt, nframes;
   bit prev_valid, v_prev;

   function automatic logic [N-1:0] exp_req(int c);
      logic [N-1:0] r = '0;
      for (int i = 0; i < N; i++)
         if (seq_on && c >= b[i] && c < b[i] + len[i]) r[i] = 1'b1;
      return r;
   endfunction

   function automatic bit exp_busy(int c);
      return seq_on && c >= s_start && c < s_end;
   endfunction

   function automatic int window(int c);
      for (int i = 0; i < N; i++)
         if (seq_on && c >= b[i] && c < b[i] + len[i]) return i;
      return -1;
   endfunction

   // Index of a client whose slot ends in a timeout at edge e, or -1 if there is none
   function automatic int to_edge(int e);
      for (int i = 0; i < N; i++)
         if (seq_on && dly[i] >= TMO && b[i] + len[i] == e) return i;
      return -1;
   endfunction

   task automatic plan(input int f);
      for (int i = 0; i < N; i++) begin
         int r = $urandom_range(0, 9);
         if (f == 0)            dly[i] = 3;
         else if (f == 1)       dly[i] = (i == 2) ? 1000 : 3;
         else if (r == 0)       dly[i] = 1000;
         else if (r == 1)       dly[i] = TMO - 1;
         else if (r == 2)       dly[i] = $urandom_range(8, 14);
         else                   dly[i] = $urandom_range(0, 4);
      end
   endtask

   task automatic start_seq(input int s);
      seq_on  = 1;
      s_start = s;
      b[0]    = s;
      for (int i = 0; i < N; i++) begin
         len[i] = (dly[i] >= TMO) ? TMO : dly[i] + 1;
         if (i < N - 1) b[i+1] = b[i] + len[i] + 1;
      end
      s_end = b[N-1] + len[N-1];
   endtask

   task automatic model_reset();
      seq_on = 0; m_ov = 0; m_to = 0; m_tidx = 0; m_cnt = 0; prev_valid = 0; v_prev = 0;
   endtask

   // Apply the inputs held during cycle cyc at the edge that ends the cycle
   task automatic model_edge();
      bit busy_c = exp_busy(cyc);
      bit rise   = prev_valid && vblnk && !v_prev;
      bit fall   = prev_valid && !vblnk && v_prev;
      int ti     = to_edge(cyc + 1);
      if (busy_c && (rise || fall)) m_ov = 1;
      else if (err_clr)             m_ov = 0;
      if (ti >= 0) begin m_to = 1; m_tidx = ti; end
      else if (err_clr) m_to = 0;
      if (rise && enable && !busy_c) begin
         plan(nframes);
         nframes++;
         start_seq(cyc + 1);
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
      v_prev = vblnk;
      prev_valid = 1;
   endtask

   task automatic check_outputs();
      check("upd_req",     32'(upd_req),     32'(exp_req(cyc)));
      check("frame_tick",  32'(frame_tick),  32'(seq_on && cyc == s_start));
      check("frame_cnt",   32'(frame_cnt),   32'(m_cnt));
      check("busy",        32'(busy),        32'(exp_busy(cyc)));
      check("overrun",     32'(overrun),     32'(m_ov));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      check("timeout_idx", 32'(timeout_idx), 32'(m_tidx));
   endtask

   // ---------------- stimulus ----------------
   bit vb_level;
   int vb_left;
   bit did_rst;

   task automatic drive_inputs();
      logic [N-1:0] ack;
      int w;
      if (vb_left == 0) begin
         vb_level = ~vb_level;
         vb_left  = vb_level ? $urandom_range(8, 90) : $urandom_range(15, 70);
      end
      vb_left--;
      vblnk = vb_level;
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      err_clr = ($urandom_range(0, 29) == 0);
      // Raise the chance that err_clr lands on the same edge as a timeout
      if (to_edge(cyc + 1) >= 0) err_clr = $urandom_range(0, 1) != 0;
      ack = N'($urandom);
      w = window(cyc);
      if (w >= 0) ack[w] = (cyc - b[w] == dly[w]);
      upd_ack = ack;
   endtask

   initial begin
      rst = 1'b1; vblnk = 1'b0; enable = 1'b1; err_clr = 1'b0; upd_ack = '0;
      vb_level = 0; vb_left = 5; nframes = 0; did_rst = 0;
      model_reset();
      repeat (3) @(negedge pclk);
      check_outputs();
      rst = 1'b0;
      while (cyc < NCYC) begin
         check_outputs();
         if (!did_rst && cyc >= NCYC / 2 && exp_req(cyc) != '0) begin
            did_rst = 1;
            #2 rst = 1'b1;
            #1;
            check("rst_upd_req",   32'(upd_req),    32'd0);
            check("rst_busy",      32'(busy),       32'd0);
            check("rst_frame_cnt", 32'(frame_cnt),  32'd0);
            check("rst_tick",      32'(frame_tick), 32'd0);
            vblnk = 1'b1; vb_level = 1; vb_left = 20;
            @(negedge pclk);
            @(negedge pclk);
            rst = 1'b0;
            cyc += 2;
            model_reset();
            check_outputs();
         end
         drive_inputs();
         model_edge();
         @(negedge pclk);
         cyc++;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
